// File: rtl/dma_pkg.sv
// Shared constants and FSM encodings for the DMA burst port and its read unpacker.
package dma_pkg;

   localparam int BURST_LEN_DEF = 16;
   localparam int MCB_CMD_BL_W  = 6;

   localparam logic [2:0] MCB_INSTR_RD = 3'b001;
   localparam logic [2:0] MCB_INSTR_WR = 3'b000;

   typedef enum logic [1:0] {R_IDLE, R_CMD, R_DATA, R_DONE} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_FILL, W_CMD, W_DONE} wr_state_t;

   // MCB burst length field counts 32-bit words minus one.
   function automatic logic [MCB_CMD_BL_W-1:0] cmd_bl(input int beats);
      return MCB_CMD_BL_W'(beats / 2 - 1);
   endfunction

endpackage

// File: rtl/dma_rd_unpack.sv
// Splits first-word-fall-through 32-bit MCB read words into two 16-bit engine beats,
// low half first, sustaining one beat per cycle.
module dma_rd_unpack #(
   parameter int BURST_LEN = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        run,
   input  logic        mr_rd_empty,
   input  logic [31:0] mr_rd_data,
   output logic        mr_rd_en,
   output logic [15:0] ob_data,
   output logic        ob_we
);

   localparam logic [7:0] WORDS = 8'(BURST_LEN / 2);

   logic [31:0] word;
   logic        held;
   logic        high_half;
   logic [7:0]  word_cnt;

   // A new word may be popped while the previous one is presenting its high half.
   assign mr_rd_en = run && !mr_rd_empty && (word_cnt < WORDS) && (!held || high_half);
   assign ob_we    = held;
   assign ob_data  = !held ? 16'h0000 : (high_half ? word[31:16] : word[15:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word      <= '0;
         held      <= 1'b0;
         high_half <= 1'b0;
         word_cnt  <= '0;
      end else begin
         if (clear) begin
            word_cnt <= '0;
         end else if (mr_rd_en) begin
            word_cnt <= word_cnt + 8'd1;
         end

         if (mr_rd_en) begin
            word      <= mr_rd_data;
            held      <= 1'b1;
            high_half <= 1'b0;
         end else if (held) begin
            if (high_half) begin
               held      <= 1'b0;
               high_half <= 1'b0;
            end else begin
               high_half <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dma_burst_port.sv
// DMA-side responder: converts engine read/write burst requests into MCB native-port
// commands, unpacking read words into beats and packing write beats into words.
module dma_burst_port
   import dma_pkg::*;
#(
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int ADDR_W    = 30
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    reads_en,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic [15:0]             ob_data,
   output logic                    ob_we,
   input  logic                    writes_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   output logic                    ib_re,
   input  logic [15:0]             ib_data,
   input  logic                    ib_valid,
   output logic                    mr_cmd_en,
   output logic [2:0]              mr_cmd_instr,
   output logic [MCB_CMD_BL_W-1:0] mr_cmd_bl,
   output logic [ADDR_W-1:0]       mr_cmd_addr,
   input  logic                    mr_cmd_full,
   output logic                    mw_cmd_en,
   output logic [2:0]              mw_cmd_instr,
   output logic [MCB_CMD_BL_W-1:0] mw_cmd_bl,
   output logic [ADDR_W-1:0]       mw_cmd_addr,
   input  logic                    mw_cmd_full,
   output logic                    mr_rd_en,
   input  logic [31:0]             mr_rd_data,
   input  logic                    mr_rd_empty,
   output logic                    mw_wr_en,
   output logic [31:0]             mw_wr_data,
   output logic [3:0]              mw_wr_mask,
   input  logic                    mw_wr_full
);

   localparam logic [7:0]        BEATS     = 8'(BURST_LEN);
   localparam logic [7:0]        WORDS     = 8'(BURST_LEN / 2);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

   rd_state_t         rd_state, rd_next;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [7:0]        rd_beats;

   wr_state_t         wr_state, wr_next;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        req_cnt;
   logic [7:0]        word_cnt;
   logic              outstanding;
   logic              have_lo;
   logic [15:0]       lo_beat;
   logic              pack_valid;
   logic              accept;

   dma_rd_unpack #(.BURST_LEN(BURST_LEN)) u_unpack (
      .clk         (clk),
      .rst         (rst),
      .clear       (rd_state == R_CMD),
      .run         (rd_state == R_DATA),
      .mr_rd_empty (mr_rd_empty),
      .mr_rd_data  (mr_rd_data),
      .mr_rd_en    (mr_rd_en),
      .ob_data     (ob_data),
      .ob_we       (ob_we)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state  <= R_IDLE;
         rd_addr_q <= '0;
         rd_beats  <= '0;
      end else begin
         rd_state <= rd_next;
         if (rd_state == R_IDLE && reads_en) begin
            rd_addr_q <= rd_addr;
            rd_beats  <= '0;
         end else if (ob_we && rd_beats != BEATS) begin
            rd_beats <= rd_beats + 8'd1;
         end
      end
   end

   always_comb begin
      rd_next   = rd_state;
      mr_cmd_en = 1'b0;
      case (rd_state)
         R_IDLE: if (reads_en) rd_next = R_CMD;
         R_CMD: begin
            if (!mr_cmd_full) begin
               mr_cmd_en = 1'b1;
               rd_next   = R_DATA;
            end
         end
         R_DATA: if (ob_we && rd_beats == BEATS - 8'd1) rd_next = R_DONE;
         // Request is a level; it must drop before another burst can start.
         R_DONE: if (!reads_en) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   assign mr_cmd_instr = (rd_state == R_CMD) ? MCB_INSTR_RD : 3'b000;
   assign mr_cmd_bl    = (rd_state == R_CMD) ? cmd_bl(BURST_LEN) : '0;
   assign mr_cmd_addr  = (rd_state == R_CMD) ? (rd_addr_q & ADDR_MASK) : '0;

   // One request in flight; the answering beat frees the slot in the same cycle.
   assign accept   = outstanding && ib_valid;
   assign ib_re    = (wr_state == W_FILL) && (req_cnt < BEATS) && !mw_wr_full &&
                     !pack_valid && (!outstanding || ib_valid);
   assign mw_wr_en = pack_valid && !mw_wr_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_state    <= W_IDLE;
         wr_addr_q   <= '0;
         req_cnt     <= '0;
         word_cnt    <= '0;
         outstanding <= 1'b0;
         have_lo     <= 1'b0;
         lo_beat     <= '0;
         pack_valid  <= 1'b0;
         mw_wr_data  <= '0;
      end else begin
         wr_state <= wr_next;
         if (wr_state == W_IDLE && writes_en) begin
            wr_addr_q   <= wr_addr;
            req_cnt     <= '0;
            word_cnt    <= '0;
            outstanding <= 1'b0;
            have_lo     <= 1'b0;
            pack_valid  <= 1'b0;
         end else begin
            if (ib_re && req_cnt != BEATS) req_cnt <= req_cnt + 8'd1;
            outstanding <= ib_re || (outstanding && !ib_valid);
            if (accept) begin
               if (!have_lo) begin
                  lo_beat <= ib_data;
                  have_lo <= 1'b1;
               end else begin
                  mw_wr_data <= {ib_data, lo_beat};
                  have_lo    <= 1'b0;
               end
            end
            if (accept && have_lo) begin
               pack_valid <= 1'b1;
            end else if (mw_wr_en) begin
               pack_valid <= 1'b0;
            end
            if (mw_wr_en && word_cnt != WORDS) word_cnt <= word_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      wr_next   = wr_state;
      mw_cmd_en = 1'b0;
      case (wr_state)
         W_IDLE: if (writes_en) wr_next = W_FILL;
         W_FILL: if (mw_wr_en && word_cnt == WORDS - 8'd1) wr_next = W_CMD;
         W_CMD: begin
            if (!mw_cmd_full) begin
               mw_cmd_en = 1'b1;
               wr_next   = W_DONE;
            end
         end
         W_DONE: if (!writes_en) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
   end

   assign mw_cmd_instr = MCB_INSTR_WR;
   assign mw_cmd_bl    = (wr_state == W_CMD) ? cmd_bl(BURST_LEN) : '0;
   assign mw_cmd_addr  = (wr_state == W_CMD) ? (wr_addr_q & ADDR_MASK) : '0;
   assign mw_wr_mask   = 4'b0000;

endmodule

// File: tb/tb_dma_burst_port.sv
// Scoreboard bench for dma_burst_port: an MCB/engine environment, a monitor checking
// every output event against queues filled from a burst-level reference model.
module tb_dma_burst_port;

   localparam int BL = 16;
   localparam int AW = 30;

   logic          clk, rst;
   logic          reads_en, writes_en;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [15:0]   ob_data, ib_data;
   logic          ob_we, ib_re, ib_valid;
   logic          mr_cmd_en, mw_cmd_en, mr_cmd_full, mw_cmd_full;
   logic [2:0]    mr_cmd_instr, mw_cmd_instr;
   logic [5:0]    mr_cmd_bl, mw_cmd_bl;
   logic [AW-1:0] mr_cmd_addr, mw_cmd_addr;
   logic          mr_rd_en, mr_rd_empty, mw_wr_en, mw_wr_full;
   logic [31:0]   mr_rd_data, mw_wr_data;
   logic [3:0]    mw_wr_mask;

   dma_burst_port #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .reads_en(reads_en), .rd_addr(rd_addr), .ob_data(ob_data), .ob_we(ob_we),
      .writes_en(writes_en), .wr_addr(wr_addr), .ib_re(ib_re), .ib_data(ib_data),
      .ib_valid(ib_valid),
      .mr_cmd_en(mr_cmd_en), .mr_cmd_instr(mr_cmd_instr), .mr_cmd_bl(mr_cmd_bl),
      .mr_cmd_addr(mr_cmd_addr), .mr_cmd_full(mr_cmd_full),
      .mw_cmd_en(mw_cmd_en), .mw_cmd_instr(mw_cmd_instr), .mw_cmd_bl(mw_cmd_bl),
      .mw_cmd_addr(mw_cmd_addr), .mw_cmd_full(mw_cmd_full),
      .mr_rd_en(mr_rd_en), .mr_rd_data(mr_rd_data), .mr_rd_empty(mr_rd_empty),
      .mw_wr_en(mw_wr_en), .mw_wr_data(mw_wr_data), .mw_wr_mask(mw_wr_mask),
      .mw_wr_full(mw_wr_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;
   int ob_seen = 0, rcmd_seen = 0, wcmd_seen = 0, rcmd_total = 0, wcmd_total = 0;
   int ib_given = 0, full_after_beat = -1, cmd_full_cnt = 0, wr_full_cnt = 0;
   bit empty_toggle = 0, rand_stall = 0, spurious = 0;

   logic [31:0]   rd_fifo[$];
   logic [15:0]   ib_src[$];
   logic [15:0]   exp_ob[$];
   logic [31:0]   exp_ww[$];
   logic [AW-1:0] exp_rcmd[$], exp_wcmd[$];
   int            ob_cyc[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_strobes", {26'b0, ob_we, ib_re, mr_cmd_en, mw_cmd_en, mr_rd_en, mw_wr_en}, 0);
      checkOutput("rst_ob_data", 32'(ob_data), 0);
      checkOutput("rst_instr_bl", {20'b0, mr_cmd_instr, mw_cmd_instr, mr_cmd_bl}, 0);
      checkOutput("rst_rd_addr", 32'(mr_cmd_addr), 0);
      checkOutput("rst_wr_addr", 32'(mw_cmd_addr), 0);
      checkOutput("rst_wr_data", mw_wr_data, 0);
      checkOutput("rst_wr_mask", 32'(mw_wr_mask), 0);
   endtask

   // Reference model: a burst reads BL/2 words, each yielding its low then high half;
   // a write burst of BL beats is sent as BL/2 words {odd beat, even beat}.
   task automatic queueRead(input logic [AW-1:0] addr, input bit pattern);
      logic [31:0] w;
      rd_addr = addr;
      for (int k = 0; k < BL / 2; k++) begin
         w = pattern ? {16'(2 * k + 2), 16'(2 * k + 1)} : $urandom;
         rd_fifo.push_back(w);
         exp_ob.push_back(w[15:0]);
         exp_ob.push_back(w[31:16]);
      end
      exp_rcmd.push_back(addr & ~AW'(3));
      rcmd_total++;
   endtask

   task automatic queueWrite(input logic [AW-1:0] addr, input bit pattern);
      logic [15:0] beats[$];
      wr_addr = addr;
      for (int i = 0; i < BL; i++) begin
         beats.push_back(pattern ? 16'hA000 + 16'(i) : 16'($urandom));
         ib_src.push_back(beats[i]);
      end
      for (int j = 0; j < BL / 2; j++) exp_ww.push_back({beats[2 * j + 1], beats[2 * j]});
      exp_wcmd.push_back(addr & ~AW'(3));
      wcmd_total++;
   endtask

   task automatic applyStimulus(input bit do_rd, input bit do_wr);
      @(posedge clk); #1;
      if (do_rd) reads_en = 1'b1;
      if (do_wr) writes_en = 1'b1;
      @(posedge clk); #1;
      rd_addr = AW'($urandom);
      wr_addr = AW'($urandom);
   endtask

   task automatic waitDone(input int budget);
      int n = 0;
      while ((exp_ob.size() + exp_ww.size() + exp_rcmd.size() + exp_wcmd.size()) != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      checkOutput("burst_timeout", 32'(exp_ob.size() + exp_ww.size() + exp_rcmd.size() + exp_wcmd.size()), 0);
   endtask

   task automatic releaseReqs();
      @(posedge clk); #1;
      reads_en  = 1'b0;
      writes_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // MCB read FIFO, write FIFO/command backpressure and engine beat source.
   initial begin
      bit do_pop, do_ib, phase;
      phase = 0;
      mr_rd_empty = 1'b1; mr_rd_data = '0; ib_valid = 1'b0; ib_data = '0;
      mr_cmd_full = 1'b0; mw_cmd_full = 1'b0; mw_wr_full = 1'b0;
      forever begin
         @(negedge clk);
         do_pop = mr_rd_en && !mr_rd_empty && !rst;
         do_ib  = ib_re && !rst;
         @(posedge clk); #1;
         if (do_pop && rd_fifo.size() > 0) void'(rd_fifo.pop_front());
         phase = !phase;
         mr_rd_empty = (rd_fifo.size() == 0) || (empty_toggle && phase) ||
                       (rand_stall && $urandom_range(0, 2) == 0);
         mr_rd_data = (rd_fifo.size() > 0) ? rd_fifo[0] : 32'h0;
         if (do_ib && ib_src.size() > 0) begin
            ib_valid = 1'b1;
            ib_data  = ib_src.pop_front();
            ib_given++;
            if (ib_given == full_after_beat) wr_full_cnt = 5;
         end else if (spurious && $urandom_range(0, 1) == 1) begin
            ib_valid = 1'b1;
            ib_data  = 16'($urandom);
         end else begin
            ib_valid = 1'b0;
            ib_data  = '0;
         end
         if (wr_full_cnt > 0) begin
            mw_wr_full = 1'b1;
            wr_full_cnt--;
         end else begin
            mw_wr_full = rand_stall && $urandom_range(0, 3) == 0;
         end
         mr_cmd_full = cmd_full_cnt > 0;
         mw_cmd_full = cmd_full_cnt > 0;
         if (cmd_full_cnt > 0) cmd_full_cnt--;
      end
   end

   // Monitor: every DUT event pops its expectation from the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (ob_we) begin
               ob_seen++;
               ob_cyc.push_back(cyc);
               if (exp_ob.size() == 0) checkOutput("ob_unexpected", 1, 0);
               else checkOutput("ob_data", 32'(ob_data), 32'(exp_ob.pop_front()));
            end
            if (mr_rd_en) checkOutput("rd_en_while_empty", 32'(mr_rd_empty), 0);
            if (ib_re) checkOutput("ib_re_while_full", 32'(mw_wr_full), 0);
            if (mr_cmd_en) begin
               rcmd_seen++;
               checkOutput("rcmd_while_full", 32'(mr_cmd_full), 0);
               checkOutput("rcmd_instr_bl", {23'b0, mr_cmd_instr, mr_cmd_bl}, {23'b0, 3'b001, 6'(BL / 2 - 1)});
               if (exp_rcmd.size() == 0) checkOutput("rcmd_unexpected", 1, 0);
               else checkOutput("rcmd_addr", 32'(mr_cmd_addr), 32'(exp_rcmd.pop_front()));
            end
            if (mw_wr_en) begin
               checkOutput("wr_en_while_full", 32'(mw_wr_full), 0);
               checkOutput("wr_mask", 32'(mw_wr_mask), 0);
               if (exp_ww.size() == 0) checkOutput("wr_unexpected", 1, 0);
               else checkOutput("wr_data", mw_wr_data, exp_ww.pop_front());
            end
            if (mw_cmd_en) begin
               wcmd_seen++;
               checkOutput("wcmd_while_full", 32'(mw_cmd_full), 0);
               checkOutput("wcmd_before_last_word", 32'(exp_ww.size()), 0);
               checkOutput("wcmd_instr_bl", {23'b0, mw_cmd_instr, mw_cmd_bl}, {23'b0, 3'b000, 6'(BL / 2 - 1)});
               if (exp_wcmd.size() == 0) checkOutput("wcmd_unexpected", 1, 0);
               else checkOutput("wcmd_addr", 32'(mw_cmd_addr), 32'(exp_wcmd.pop_front()));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int start, n;
      rst = 1'b1; reads_en = 1'b0; writes_en = 1'b0; rd_addr = '0; wr_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetOutputs();
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] fixed read burst, reads_en held high");
      ob_cyc.delete();
      queueRead(AW'('h100), 1'b1);
      applyStimulus(1'b1, 1'b0);
      waitDone(200);
      checkOutput("rd_back_to_back", (ob_cyc.size() == BL) ? 32'(ob_cyc[BL - 1] - ob_cyc[0]) : 32'hFFFF, BL - 1);
      repeat (20) @(posedge clk);
      checkOutput("rd_cmd_count", 32'(rcmd_seen), 32'(rcmd_total));
      releaseReqs();

      $display("[TB] read burst with toggling empty");
      empty_toggle = 1;
      queueRead(AW'($urandom), 1'b0);
      applyStimulus(1'b1, 1'b0);
      waitDone(300);
      releaseReqs();
      empty_toggle = 0;

      $display("[TB] fixed write burst with stray ib_valid");
      spurious = 1;
      queueWrite(AW'('h203), 1'b1);
      applyStimulus(1'b0, 1'b1);
      waitDone(300);
      checkOutput("wr_cmd_count", 32'(wcmd_seen), 32'(wcmd_total));
      releaseReqs();
      spurious = 0;

      $display("[TB] write burst with write FIFO full after beat 6");
      ib_given = 0;
      full_after_beat = 6;
      queueWrite(AW'($urandom), 1'b1);
      applyStimulus(1'b0, 1'b1);
      waitDone(300);
      releaseReqs();
      full_after_beat = -1;

      $display("[TB] concurrent read and write with command FIFOs full");
      @(negedge clk);
      cmd_full_cnt = 5;
      queueRead(AW'($urandom), 1'b0);
      queueWrite(AW'($urandom), 1'b0);
      applyStimulus(1'b1, 1'b1);
      waitDone(400);
      releaseReqs();

      $display("[TB] reset in the middle of a read burst");
      queueRead(AW'($urandom), 1'b0);
      start = ob_seen;
      applyStimulus(1'b1, 1'b0);
      n = 0;
      while (ob_seen < start + 6 && n < 200) begin
         @(posedge clk);
         n++;
      end
      checkOutput("rd_beats_before_reset", 32'(ob_seen - start >= 6), 1);
      #1 rst = 1'b1;
      @(negedge clk);
      checkResetOutputs();
      exp_ob.delete();
      rd_fifo.delete();
      exp_rcmd.delete();
      reads_en = 1'b0;
      queueRead(AW'($urandom), 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      start = ob_seen;
      applyStimulus(1'b1, 1'b0);
      waitDone(300);
      checkOutput("rd_beats_after_reset", 32'(ob_seen - start), BL);
      releaseReqs();

      $display("[TB] random concurrent bursts with random stalls");
      rand_stall = 1;
      for (int r = 0; r < 3; r++) begin
         queueRead(AW'($urandom), 1'b0);
         queueWrite(AW'($urandom), 1'b0);
         applyStimulus(1'b1, 1'b1);
         waitDone(800);
         releaseReqs();
      end
      rand_stall = 0;

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
